mat_mult_ctrl: RTL and testbench

Streaming front/back end for the `mat_mult` array multiplier. It accepts two square matrices as a row-major element stream and registers them onto the multiplier's `mat1`/`mat2` inputs. It then holds `enable_mult` until `mult_done`, captures `mat_out`, and serialises the result back out as a row-major element stream with valid/ready handshakes.

---
 rtl/mat_mult_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mat_mult_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_ctrl.sv
// Streaming load / run / drain controller wrapped around the mat_mult array multiplier.
// Optional RUN watchdog enabled by defining MAT_MULT_CTRL_TIMEOUT_EN.
module mat_mult_ctrl #(
  parameter int N_ROWS    = 2,
  parameter int N_COLUMNS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_data,
  output logic signed [31:0] mat1 [N_ROWS][N_COLUMNS],
  output logic signed [31:0] mat2 [N_ROWS][N_COLUMNS],
  output logic               enable_mult,
  input  logic               mult_done,
  input  logic signed [31:0] mat_out [N_ROWS][N_COLUMNS],
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_data,
  output logic               out_last,
  output logic               timeout_err
);

  localparam int E   = N_ROWS * N_COLUMNS;
  localparam int KW  = $clog2(E + 1);
  localparam int RCW = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0]  K_LAST  = KW'(E - 1);
  localparam logic [RCW-1:0] RUN_MAX = {RCW{1'b1}};
`ifdef MAT_MULT_CTRL_TIMEOUT_EN
  localparam logic [RCW-1:0] RUN_LAST = RCW'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t             state_r;
  logic [KW-1:0]      k_r;
  logic [RCW-1:0]     run_cnt_r;
  logic               enable_r;
  logic               out_valid_r;
  logic signed [31:0] out_data_r;
  logic               out_last_r;
  logic signed [31:0] mat1_r   [N_ROWS][N_COLUMNS];
  logic signed [31:0] mat2_r   [N_ROWS][N_COLUMNS];
  logic signed [31:0] result_r [N_ROWS][N_COLUMNS];
  logic signed [31:0] next_elem_s;
`ifdef MAT_MULT_CTRL_TIMEOUT_EN
  logic               timeout_err_r;
`endif

  assign in_ready    = (state_r == LOAD_A) || (state_r == LOAD_B);
  assign enable_mult = enable_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_last    = out_last_r;
  assign mat1        = mat1_r;
  assign mat2        = mat2_r;
`ifdef MAT_MULT_CTRL_TIMEOUT_EN
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

  // Select the result element that follows the one currently presented.
  always_comb begin
    next_elem_s = 32'sd0;
    for (int r = 0; r < N_ROWS; r++) begin
      for (int c = 0; c < N_COLUMNS; c++) begin
        next_elem_s = (int'(k_r) + 1 == r * N_COLUMNS + c) ? result_r[r][c] : next_elem_s;
      end
    end
  end

  // Controller FSM: operand loading, multiply handshake, result serialisation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= LOAD_A;
      k_r         <= {KW{1'b0}};
      run_cnt_r   <= {RCW{1'b0}};
      enable_r    <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'sd0;
      out_last_r  <= 1'b0;
`ifdef MAT_MULT_CTRL_TIMEOUT_EN
      timeout_err_r <= 1'b0;
`endif
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLUMNS; c++) begin
          mat1_r[r][c]   <= 32'sd0;
          mat2_r[r][c]   <= 32'sd0;
          result_r[r][c] <= 32'sd0;
        end
      end
    end else begin
      case (state_r)
        LOAD_A: begin
          if (in_valid) begin
            for (int r = 0; r < N_ROWS; r++) begin
              for (int c = 0; c < N_COLUMNS; c++) begin
                if (k_r == KW'(r * N_COLUMNS + c)) mat1_r[r][c] <= in_data;
              end
            end
`ifdef MAT_MULT_CTRL_TIMEOUT_EN
            timeout_err_r <= 1'b0;
`endif
            if (k_r == K_LAST) begin
              k_r     <= {KW{1'b0}};
              state_r <= LOAD_B;
            end else begin
              k_r <= k_r + KW'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            for (int r = 0; r < N_ROWS; r++) begin
              for (int c = 0; c < N_COLUMNS; c++) begin
                if (k_r == KW'(r * N_COLUMNS + c)) mat2_r[r][c] <= in_data;
              end
            end
            if (k_r == K_LAST) begin
              k_r       <= {KW{1'b0}};
              enable_r  <= 1'b1;
              run_cnt_r <= {RCW{1'b0}};
              state_r   <= RUN;
            end else begin
              k_r <= k_r + KW'(1);
            end
          end
        end
        RUN: begin
          // A done seen on the first RUN cycle may be left over from the previous job.
          if (mult_done && (run_cnt_r != {RCW{1'b0}})) begin
            result_r    <= mat_out;
            enable_r    <= 1'b0;
            out_valid_r <= 1'b1;
            out_data_r  <= mat_out[0][0];
            out_last_r  <= (K_LAST == KW'(0));
            k_r         <= {KW{1'b0}};
            state_r     <= DRAIN;
          end
`ifdef MAT_MULT_CTRL_TIMEOUT_EN
          else if (run_cnt_r == RUN_LAST) begin
            timeout_err_r <= 1'b1;
            enable_r      <= 1'b0;
            k_r           <= {KW{1'b0}};
            state_r       <= LOAD_A;
          end
`endif
          else if (run_cnt_r != RUN_MAX) begin
            run_cnt_r <= run_cnt_r + RCW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (k_r == K_LAST) begin
              out_valid_r <= 1'b0;
              out_data_r  <= 32'sd0;
              out_last_r  <= 1'b0;
              k_r         <= {KW{1'b0}};
              state_r     <= LOAD_A;
            end else begin
              k_r        <= k_r + KW'(1);
              out_data_r <= next_elem_s;
              out_last_r <= (k_r + KW'(1) == K_LAST);
            end
          end
        end
        default: begin
          state_r <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// Self-checking bench for mat_mult_ctrl (2x2) with a behavioural multiplier stub.
module tb_mat_mult_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [31:0] in_data = 32'sd0;
  logic signed [31:0] mat1 [2][2];
  logic signed [31:0] mat2 [2][2];
  logic enable_mult;
  logic mult_done = 1'b0;
  logic signed [31:0] mat_out [2][2];
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [31:0] out_data;
  logic out_last;
  logic timeout_err;

  int checks = 0;
  int errors = 0;
  bit stale_mode = 1'b0;
  int mult_lat = 1;
  int mult_cnt = 0;

  typedef struct packed {
    logic [0:3][31:0] a;
    logic [0:3][31:0] b;
    logic [0:3][31:0] y;
    logic [7:0]       lat;
    logic             gaps;
    logic             bp;
  } vec_t;

  mat_mult_ctrl #(.N_ROWS(2), .N_COLUMNS(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mat1(mat1), .mat2(mat2),
    .enable_mult(enable_mult), .mult_done(mult_done), .mat_out(mat_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Multiplier stub: done after mult_lat enabled cycles, or stuck-done with all-7 result.
  always @(posedge clk) begin
    if (stale_mode) begin
      mult_done <= 1'b1;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) mat_out[r][c] <= 32'sd7;
    end else if (!enable_mult) begin
      mult_cnt  <= 0;
      mult_done <= 1'b0;
    end else begin
      mult_cnt <= mult_cnt + 1;
      if (mult_cnt + 1 >= mult_lat) begin
        mult_done <= 1'b1;
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            mat_out[r][c] <= mat1[r][0] * mat2[0][c] + mat1[r][1] * mat2[1][c];
      end
    end
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [0:3][31:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {e0, e1, e2, e3};
  endfunction

  // Reference: plain row-major matrix product.
  function automatic void model(input int a[4], input int b[4], output int y[4]);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        y[r*2+c] = 0;
        for (int i = 0; i < 2; i++) y[r*2+c] += a[r*2+i] * b[i*2+c];
      end
  endfunction

  task automatic send(input int v[8], input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    bit tog = 1'b0;
    while (i < n && guard < 100) begin
      @(negedge clk);
      chk("enable_low_during_load", enable_mult, 1'b0);
      tog = gaps ? ~tog : 1'b1;
      in_valid = tog;
      in_data = v[i];
      if (in_valid && in_ready) i++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 32'sd0;
    if (i < n) begin
      checks++; errors++;
      $display("FAIL send_timeout: accepted %0d, expected %0d", i, n);
    end
  endtask

  task automatic drain(input int y[4], input bit bp_alt, input bit bp_rand);
    int n = 0;
    int guard = 0;
    bit stalled = 1'b0;
    bit ph = 1'b0;
    logic signed [31:0] held = 32'sd0;
    while (n < 4 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (out_valid) begin
        if (stalled) chk("hold_stable", out_data, held);
        chk("out_data", out_data, y[n]);
        chk("out_last", out_last, (n == 3));
        ph = ~ph;
        out_ready = bp_rand ? 1'($urandom_range(0, 1)) : (bp_alt ? ~ph : 1'b1);
        if (out_ready) begin
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end else begin
        out_ready = 1'b0;
        chk("idle_out_data", out_data, 32'sd0);
        chk("idle_out_last", out_last, 1'b0);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    if (n < 4) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d elements, expected 4", n);
    end
    chk("in_ready_after_drain", in_ready, 1'b1);
    chk("out_valid_after_drain", out_valid, 1'b0);
    chk("out_data_after_drain", out_data, 32'sd0);
  endtask

  task automatic run_txn(input int a[4], input int b[4], input int y[4], input int lat,
                         input bit gaps, input bit bp_alt, input bit bp_rand);
    int v[8];
    mult_lat = lat;
    for (int i = 0; i < 4; i++) begin
      v[i] = a[i];
      v[i+4] = b[i];
    end
    send(v, 8, gaps);
    chk("enable_rise", enable_mult, 1'b1);
    chk("in_ready_run", in_ready, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        chk("mat1", mat1[r][c], a[r*2+c]);
        chk("mat2", mat2[r][c], b[r*2+c]);
      end
    chk("no_early_valid", out_valid, 1'b0);
    for (int j = 0; j < lat; j++) begin
      @(negedge clk);
      chk("no_early_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    chk("valid_on_capture", out_valid, 1'b1);
    chk("enable_drop", enable_mult, 1'b0);
    drain(y, bp_alt, bp_rand);
  endtask

  initial begin
    vec_t tbl[5];
    int a[4], b[4], y[4], v[8];

    tbl[0] = '{a: pk(1, 2, 3, 4),   b: pk(5, 6, 7, 8),   y: pk(19, 22, 43, 50),   lat: 8'd1, gaps: 1'b0, bp: 1'b0};
    tbl[1] = '{a: pk(1, 2, 3, 4),   b: pk(5, 6, 7, 8),   y: pk(19, 22, 43, 50),   lat: 8'd3, gaps: 1'b0, bp: 1'b1};
    tbl[2] = '{a: pk(1, 2, 3, 4),   b: pk(5, 6, 7, 8),   y: pk(19, 22, 43, 50),   lat: 8'd2, gaps: 1'b1, bp: 1'b0};
    tbl[3] = '{a: pk(1, 0, 0, 1),   b: pk(9, -3, 4, 2),  y: pk(9, -3, 4, 2),      lat: 8'd5, gaps: 1'b1, bp: 1'b1};
    tbl[4] = '{a: pk(-1, 2, 0, 3),  b: pk(4, 5, -6, 7),  y: pk(-16, 9, -18, 21),  lat: 8'd1, gaps: 1'b0, bp: 1'b0};

    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_enable", enable_mult, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'sd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_mat1", mat1[1][1], 32'sd0);
    chk("rst_mat2", mat2[0][1], 32'sd0);
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < 4; j++) begin
        a[j] = int'($signed(tbl[t].a[j]));
        b[j] = int'($signed(tbl[t].b[j]));
        y[j] = int'($signed(tbl[t].y[j]));
      end
      run_txn(a, b, y, int'(tbl[t].lat), tbl[t].gaps, tbl[t].bp, 1'b0);
    end

    // Stuck-high done must not be captured on the first RUN cycle.
    stale_mode = 1'b1;
    for (int j = 0; j < 4; j++) begin
      a[j] = j + 1;
      b[j] = j + 5;
      y[j] = 7;
    end
    run_txn(a, b, y, 1, 1'b0, 1'b0, 1'b0);
    stale_mode = 1'b0;
    @(negedge clk);

    // Reset after mat1 plus two elements of mat2.
    for (int j = 0; j < 8; j++) v[j] = j + 1;
    send(v, 6, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_enable", enable_mult, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, 32'sd0);
    chk("mid_rst_out_last", out_last, 1'b0);
    chk("mid_rst_mat1", mat1[0][0], 32'sd0);
    chk("mid_rst_mat2", mat2[0][1], 32'sd0);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      a[j] = j + 1;
      b[j] = j + 5;
    end
    model(a, b, y);
    run_txn(a, b, y, 2, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      for (int j = 0; j < 4; j++) begin
        a[j] = int'($urandom_range(0, 200)) - 100;
        b[j] = int'($urandom_range(0, 200)) - 100;
      end
      model(a, b, y);
      run_txn(a, b, y, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end

`ifdef MAT_MULT_CTRL_TIMEOUT_EN
    mult_lat = 100000;
    for (int j = 0; j < 8; j++) v[j] = j + 1;
    send(v, 8, 1'b0);
    chk("to_err_run1", timeout_err, 1'b0);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      chk("to_err_early", timeout_err, 1'b0);
      chk("to_no_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    chk("to_err_set", timeout_err, 1'b1);
    chk("to_enable_low", enable_mult, 1'b0);
    chk("to_in_ready", in_ready, 1'b1);
    chk("to_no_valid", out_valid, 1'b0);
    in_valid = 1'b1;
    in_data = 32'sd11;
    @(negedge clk);
    in_valid = 1'b0;
    chk("to_err_clear", timeout_err, 1'b0);
    chk("to_mat1_reload", mat1[0][0], 32'sd11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
